// File: rtl/cfa_pkg.sv
// rtl/cfa_pkg.sv - shared types and constants for the CFA raster generator
package cfa_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } raster_state_t;

    localparam logic [1:0] CFA_R  = 2'b00;
    localparam logic [1:0] CFA_GR = 2'b01;
    localparam logic [1:0] CFA_GB = 2'b10;
    localparam logic [1:0] CFA_B  = 2'b11;

    localparam int CFA_IMG_W  = 512;
    localparam int CFA_IMG_H  = 256;
    localparam int CFA_ADDR_W = 17;

endpackage

// File: rtl/cfa_raster_gen_if.sv
// rtl/cfa_raster_gen_if.sv - control and beat signals of the CFA raster generator
interface cfa_raster_if
    import cfa_pkg::*;
#(
    parameter int ADDR_W = CFA_ADDR_W,
    parameter int X_W    = $clog2(CFA_IMG_W),
    parameter int Y_W    = $clog2(CFA_IMG_H)
);
    logic              start;
    logic              cont;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic              en;
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [1:0]        cfa_phase;
    logic              sof;
    logic              eol;
    logic              eof;
    logic              busy;
    logic              done;

    // master is the generator issuing beats; slave is the frame-buffer/demosaic side
    modport master (
        input  start, cont, abort, base_addr, en,
        output valid, address, x, y, cfa_phase, sof, eol, eof, busy, done
    );

    modport slave (
        output start, cont, abort, base_addr, en,
        input  valid, address, x, y, cfa_phase, sof, eol, eof, busy, done
    );

endinterface

// File: rtl/cfa_wrap_cnt.sv
// rtl/cfa_wrap_cnt.sv - wrapping counter with enable, synchronous clear-load and terminal count
module cfa_wrap_cnt #(
    parameter int W   = 9,
    parameter int MAX = 511
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         load_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    localparam logic [W-1:0] LAST = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/cfa_raster_gen.sv
// rtl/cfa_raster_gen.sv - raster address generator walking an IMG_W x IMG_H frame with Bayer tags
module cfa_raster_gen
    import cfa_pkg::*;
#(
    parameter int IMG_W  = CFA_IMG_W,
    parameter int IMG_H  = CFA_IMG_H,
    parameter int ADDR_W = CFA_ADDR_W,
    parameter int X_W    = $clog2(IMG_W),
    parameter int Y_W    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    cfa_raster_if.master  bus
);
    raster_state_t     state_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] base_q;

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           x_tc;
    logic           y_tc;
    logic           accept;
    logic           last_beat;
    logic           start_ok;

    assign accept    = valid_q && bus.en;
    assign last_beat = accept && x_tc && y_tc;
    assign start_ok  = (state_q == IDLE) && bus.start && !bus.abort;

    // both counters wrap to (0,0) on their own after the last pixel, so a
    // continuous-mode reload needs no explicit clear
    cfa_wrap_cnt #(.W(X_W), .MAX(IMG_W - 1)) u_x_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (accept),
        .load_i (start_ok),
        .cnt_o  (x_q),
        .tc_o   (x_tc)
    );

    cfa_wrap_cnt #(.W(Y_W), .MAX(IMG_H - 1)) u_y_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (accept && x_tc),
        .load_i (start_ok),
        .cnt_o  (y_q),
        .tc_o   (y_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            base_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            base_q  <= bus.base_addr;
                            addr_q  <= bus.base_addr;
                        end
                    end
                    RUN: begin
                        if (last_beat) begin
                            done_q <= 1'b1;
                            if (bus.cont) begin
                                addr_q <= base_q;
                            end else begin
                                state_q <= IDLE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end else if (accept) begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.valid     = valid_q;
    assign bus.address   = addr_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    // markers are gated by valid so they read 0 whenever no beat is presented
    assign bus.sof       = valid_q && (x_q == '0) && (y_q == '0);
    assign bus.eol       = valid_q && x_tc;
    assign bus.eof       = valid_q && x_tc && y_tc;
    assign bus.cfa_phase = valid_q ? {y_q[0], x_q[0]} : CFA_R;

endmodule

// File: tb/tb_cfa_raster_gen.sv
// tb/tb_cfa_raster_gen.sv - self-checking bench for cfa_raster_gen on a 4x3 frame
module tb_cfa_raster_gen;

    localparam int W      = 4;
    localparam int H      = 3;
    localparam int ADDR_W = 17;
    localparam int NPIX   = W * H;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cfa_raster_if #(.ADDR_W(ADDR_W), .X_W(2), .Y_W(2)) bus ();

    cfa_raster_gen #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (ADDR_W),
        .X_W    (2),
        .Y_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s beat=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // expected beat k of a frame, straight from raster-order arithmetic
    task automatic check_beat(input int k, input logic [ADDR_W-1:0] base, input bit done_e);
        int ex;
        int ey;
        logic [ADDR_W-1:0] ea;
        ex = k % W;
        ey = k / W;
        ea = base + ADDR_W'(ey * W + ex);
        chk("valid", k, 32'(bus.valid), 32'(1));
        chk("address", k, 32'(bus.address), 32'(ea));
        chk("x", k, 32'(bus.x), 32'(ex));
        chk("y", k, 32'(bus.y), 32'(ey));
        chk("cfa_phase", k, 32'(bus.cfa_phase), 32'((ey % 2) * 2 + (ex % 2)));
        chk("sof", k, 32'(bus.sof), 32'(k == 0));
        chk("eol", k, 32'(bus.eol), 32'(ex == W - 1));
        chk("eof", k, 32'(bus.eof), 32'(k == NPIX - 1));
        chk("busy", k, 32'(bus.busy), 32'(1));
        chk("done", k, 32'(bus.done), 32'(done_e));
    endtask

    task automatic check_idle(input string tag, input bit done_e);
        chk({tag, "_valid"}, -1, 32'(bus.valid), 32'(0));
        chk({tag, "_busy"}, -1, 32'(bus.busy), 32'(0));
        chk({tag, "_done"}, -1, 32'(bus.done), 32'(done_e));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, -1, 32'(bus.valid), 32'(0));
        chk({tag, "_address"}, -1, 32'(bus.address), 32'(0));
        chk({tag, "_x"}, -1, 32'(bus.x), 32'(0));
        chk({tag, "_y"}, -1, 32'(bus.y), 32'(0));
        chk({tag, "_phase"}, -1, 32'(bus.cfa_phase), 32'(0));
        chk({tag, "_sof"}, -1, 32'(bus.sof), 32'(0));
        chk({tag, "_eol"}, -1, 32'(bus.eol), 32'(0));
        chk({tag, "_eof"}, -1, 32'(bus.eof), 32'(0));
        chk({tag, "_busy"}, -1, 32'(bus.busy), 32'(0));
        chk({tag, "_done"}, -1, 32'(bus.done), 32'(0));
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        bus.base_addr = b;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.base_addr = ADDR_W'($urandom);
    endtask

    task automatic run_beats(input logic [ADDR_W-1:0] base, input int n, input bit done_first);
        for (int k = 0; k < n; k++) begin
            check_beat(k, base, done_first && (k == 0));
            step();
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] base;
        int k;
        int cyc;

        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.cont      = 1'b0;
        bus.abort     = 1'b0;
        bus.en        = 1'b1;
        bus.base_addr = '0;

        #12;
        check_all_zero("reset");
        rst = 1'b1;
        step();
        check_idle("post_reset", 1'b0);

        // plain frame from 0x10
        base = 17'h10;
        do_start(base);
        run_beats(base, NPIX, 1'b0);
        check_idle("frame_end", 1'b1);
        step();
        check_idle("frame_after", 1'b0);

        // randomised downstream stalls; every stalled cycle must repeat the same beat
        base = 17'h10;
        do_start(base);
        k   = 0;
        cyc = 0;
        while (k < NPIX && cyc < 400) begin
            check_beat(k, base, 1'b0);
            bus.en = 1'($urandom_range(0, 1));
            step();
            if (bus.en) k++;
            cyc++;
        end
        chk("stall_beats", cyc, 32'(k), 32'(NPIX));
        bus.en = 1'b1;
        check_idle("stall_end", 1'b1);
        step();

        // continuous mode: second frame follows with no bubble
        base     = 17'h10;
        bus.cont = 1'b1;
        do_start(base);
        run_beats(base, NPIX, 1'b0);
        bus.cont = 1'b0;
        run_beats(base, NPIX, 1'b1);
        check_idle("cont_end", 1'b1);
        step();

        // address wrap past 2^ADDR_W
        base = 17'h1FFFA;
        do_start(base);
        run_beats(base, NPIX, 1'b0);
        check_idle("wrap_end", 1'b1);
        step();

        // abort on beat 5
        base = ADDR_W'($urandom);
        do_start(base);
        run_beats(base, 5, 1'b0);
        check_beat(5, base, 1'b0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_idle("abort", 1'b0);
        step();
        check_idle("abort_after", 1'b0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_idle("start_abort", 1'b0);
        base = ADDR_W'($urandom);
        do_start(base);
        run_beats(base, NPIX, 1'b0);
        check_idle("restart_end", 1'b1);
        step();

        // asynchronous reset mid-frame, then phase sequence of a fresh frame
        base = ADDR_W'($urandom);
        do_start(base);
        run_beats(base, 6, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        #2;
        rst = 1'b1;
        step();
        check_idle("midrst_after", 1'b0);
        base = 17'h0;
        do_start(base);
        run_beats(base, NPIX, 1'b0);
        check_idle("final_end", 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfa_raster_gen.md
# cfa_raster_gen

Parametrised raster address generator for the CFA pipeline, replacing the fixed 17-bit free-running frame address counter. It walks a `IMG_W` x `IMG_H` frame pixel by pixel from a programmable base address and issues one beat per cycle under a valid/enable handshake. Each beat also carries x/y coordinates, the Bayer phase of the pixel and frame/line markers. It feeds the frame-buffer read port and the demosaic window logic.

## Interface
- `IMG_W`, default 512: pixels per line, ≥2.
- `IMG_H`, default 256: lines per frame, ≥2.
- `ADDR_W`, default 17: address width, ≥ clog2(`IMG_W`*`IMG_H`).
- `X_W`, default clog2(`IMG_W`): x coordinate width.
- `Y_W`, default clog2(`IMG_H`): y coordinate width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `cont`  in  1  continuous mode; sampled on the last beat of each frame.
- `abort`  in  1  synchronous abort; overrides all other inputs except `rst`.
- `base_addr`  in  `ADDR_W`  frame base; captured on accepted `start`.
- `en`  in  1  downstream ready; a beat is accepted when `valid && en`.
- `valid`  out  1  current beat valid.
- `address`  out  `ADDR_W`  pixel address, equal to base + y*`IMG_W` + x, modulo 2^`ADDR_W`.
- `x`  out  `X_W`  column of the current beat.
- `y`  out  `Y_W`  row of the current beat.
- `cfa_phase`  out  2  {y[0], x[0]}: 00 = R, 01 = Gr, 10 = Gb, 11 = B.
- `sof`  out  1  current beat is (0,0).
- `eol`  out  1  x == `IMG_W`-1.
- `eof`  out  1  last pixel of the frame.
- `busy`  out  1  state is RUN.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, RUN.
- IDLE → RUN when `start`=1: capture `base_addr`; x=0, y=0, `address`=base.
- In RUN, on an accepted beat:
  - x increments and `address` increments by 1.
  - At x=`IMG_W`-1: x returns to 0 and y increments.
  - `address` stays incremental; no multiplier.
- When `en`=0 in RUN, all outputs hold; `valid` stays 1.
- Last beat accepted with `cont`=0: go to IDLE, pulse `done`, drop `valid`.
- Last beat accepted with `cont`=1: stay in RUN, reload x=0, y=0, `address`=captured base; pulse `done`. No bubble.
- `start` in RUN is ignored. `base_addr` changes in RUN are ignored.
- `abort`=1 in any state: next cycle is IDLE with `valid`=0 and no `done`. Coordinates and address are left at don't-care.
- `address` wraps modulo 2^`ADDR_W` with no flag.
- `sof`, `eol`, `eof` and `cfa_phase` are decoded from the registered x/y and are valid only while `valid`=1.

## Timing
- Reset values:
  - state IDLE; `valid`, `busy`, `done` = 0.
  - `address`, `x`, `y` = 0; captured base = 0.
  - `sof`, `eol`, `eof`, `cfa_phase` = 0.
- Latency from `start` high in cycle N:
  - `valid`=1 with `sof`=1 in cycle N+1.
  - With `en` held high, the frame completes in `IMG_W`*`IMG_H` cycles.
  - `eof` beat is in cycle N + `IMG_W`*`IMG_H`; `done` in the following cycle.
- `done` coincides with IDLE (`cont`=0) or with the `sof` beat of the next frame (`cont`=1).
- `start` together with `abort` in IDLE: `abort` wins, state stays IDLE.
- `rst` mid-frame: outputs take their reset values immediately; no `done`.

## Structure
- Shared package `cfa_pkg` holds:
  - State enum `raster_state_t` {IDLE, RUN}.
  - Bayer phase localparams `CFA_R`, `CFA_GR`, `CFA_GB`, `CFA_B`.
  - Default frame constants `CFA_IMG_W`=512, `CFA_IMG_H`=256, `CFA_ADDR_W`=17.
- One sub-module, `cfa_wrap_cnt`: a parametrised counter with enable, synchronous load, and terminal-count output. It is instantiated twice: x counter, and y counter chained on the x terminal count.
- FSM, address register and flag decode live in the top module.

## Test plan
- `IMG_W`=4, `IMG_H`=3, base=0x10, `en`=1, `start` pulse:
  - 12 beats with addresses 0x10..0x1B.
  - `sof` only on the first beat; `eol` on x=3; `eof` on addr 0x1B.
  - `done` the cycle after the last beat; `busy` falls the same cycle.
- Same config with `en` toggling 1,0,0,1,…:
  - Outputs hold while `en`=0.
  - Exactly 12 accepted beats; address sequence unchanged.
- `cont`=1: no idle cycle between frames.
  - The beat after addr 0x1B is 0x10 with `sof`=1 and `done`=1 in the same cycle.
- Base=0x1FFFA with 12 pixels:
  - Address wraps 0x1FFFF → 0x00000.
  - Last address 0x00005; x/y unaffected.
- `abort` asserted at beat 5:
  - `valid`=0 the next cycle; no `done`.
  - A new `start` restarts at (0,0) with a fresh base.
- `rst` driven low mid-frame and `cfa_phase` check:
  - On `rst` low, all outputs read 0 asynchronously.
  - After reset release and `start`, `cfa_phase` sequence is 00,01,00,01,10,11,10,11,…
